// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
//   Shared widths and the FSM state type for the toll-exit fee scheduler.
//   TIME_W : width of entry/exit timestamps
//   ID_W   : width of a vehicle ID
//   FEE_W  : width of a computed fee
//   state_e: scheduler FSM states (IDLE, ISSUE, WAIT, RESPOND)
// -----------------------------------------------------------------------------
package parking_pkg;
   localparam int TIME_W = 32;
   localparam int ID_W   = 8;
   localparam int FEE_W  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick among NUM_LANES requesters. The search
//   starts at last_grant+1 (wrapping), so last_grant itself has lowest priority.
//   Ports:
//     req         in  NUM_LANES  request vector
//     last_grant  in  IDX_W      index granted most recently
//     grant_valid out 1          at least one request present
//     grant_idx   out IDX_W      selected lane (last_grant when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NUM_LANES = 4,
   localparam int IDX_W     = $clog2(NUM_LANES)
) (
   input  logic [NUM_LANES-1:0] req,
   input  logic [IDX_W-1:0]     last_grant,
   output logic                 grant_valid,
   output logic [IDX_W-1:0]     grant_idx
);

   always_comb begin
      int cand;
      grant_valid = 1'b0;
      grant_idx   = last_grant;
      cand        = 0;
      // Walk from the farthest candidate to the nearest; the last hit
      // written is the nearest requester after last_grant.
      for (int k = NUM_LANES; k >= 1; k--) begin
         cand = int'(last_grant) + k;
         if (cand >= NUM_LANES) cand = cand - NUM_LANES;
         if (req[IDX_W'(cand)]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/fee_lane_scheduler.sv
// -----------------------------------------------------------------------------
// fee_lane_scheduler
//   Shares one fee calculator between NUM_LANES exit lanes. A lane is picked
//   round-robin, its operands are latched and presented to the calculator, the
//   result is waited for (with timeout) and returned to the lane as a one-cycle
//   done (or error) pulse.
//   Ports:
//     clk, reset                 clock, async active-high reset
//     lane_req[N]                level request per lane
//     lane_entry_time/exit_time  packed 32-bit timestamps per lane
//     lane_vehicle_id            packed 8-bit IDs per lane
//     lane_done/lane_error[N]    one-hot completion pulses
//     lane_fee                   fee for the last completion (0 on error)
//     calc_start                 one-cycle start pulse to the calculator
//     calc_entry_time/exit_time/vehicle_id  latched operands
//     calc_fee_amount/valid      calculator result
//     busy                       high whenever not IDLE
//     active_lane                lane being served
// -----------------------------------------------------------------------------
module fee_lane_scheduler
   import parking_pkg::*;
#(
   parameter  int NUM_LANES      = 4,
   parameter  int TIMEOUT_CYCLES = 64,
   localparam int LANE_W         = $clog2(NUM_LANES)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_LANES-1:0]        lane_req,
   input  logic [TIME_W*NUM_LANES-1:0] lane_entry_time,
   input  logic [TIME_W*NUM_LANES-1:0] lane_exit_time,
   input  logic [ID_W*NUM_LANES-1:0]   lane_vehicle_id,
   output logic [NUM_LANES-1:0]        lane_done,
   output logic [NUM_LANES-1:0]        lane_error,
   output logic [FEE_W-1:0]            lane_fee,
   output logic                        calc_start,
   output logic [TIME_W-1:0]           calc_entry_time,
   output logic [TIME_W-1:0]           calc_exit_time,
   output logic [ID_W-1:0]             calc_vehicle_id,
   input  logic [FEE_W-1:0]            calc_fee_amount,
   input  logic                        calc_fee_valid,
   output logic                        busy,
   output logic [LANE_W-1:0]           active_lane
);

   localparam int                   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_LANES-1:0] LANE0    = NUM_LANES'(1);

   state_e            state_q, state_d;
   logic [LANE_W-1:0] last_grant_q, last_grant_d;
   logic [LANE_W-1:0] active_lane_q, active_lane_d;
   logic [TIME_W-1:0] entry_q, entry_d;
   logic [TIME_W-1:0] exit_q, exit_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [FEE_W-1:0]  fee_q, fee_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              armed_q, armed_d;
   logic              err_q, err_d;
   logic              mask_q, mask_d;

   logic [TIME_W-1:0] entry_arr [NUM_LANES];
   logic [TIME_W-1:0] exit_arr  [NUM_LANES];
   logic [ID_W-1:0]   id_arr    [NUM_LANES];

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_unpack
      assign entry_arr[i] = lane_entry_time[i*TIME_W +: TIME_W];
      assign exit_arr[i]  = lane_exit_time[i*TIME_W +: TIME_W];
      assign id_arr[i]    = lane_vehicle_id[i*ID_W +: ID_W];
   end

   logic [NUM_LANES-1:0] mask_vec, req_eff, active_vec;
   logic                 grant_valid;
   logic [LANE_W-1:0]    grant_idx;

   // Right after a response the just-served lane is hidden for one IDLE
   // cycle, so a requester that drops req a cycle late is not served twice.
   assign mask_vec   = mask_q ? (LANE0 << last_grant_q) : '0;
   assign req_eff    = lane_req & ~mask_vec;
   assign active_vec = LANE0 << active_lane_q;

   rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
      .req         (req_eff),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      active_lane_d = active_lane_q;
      entry_d       = entry_q;
      exit_d        = exit_q;
      id_d          = id_q;
      fee_d         = fee_q;
      cnt_d         = cnt_q;
      armed_d       = armed_q;
      err_d         = err_q;
      mask_d        = mask_q;
      calc_start    = 1'b0;
      lane_done     = '0;
      lane_error    = '0;
      busy          = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            mask_d = 1'b0;
            if (grant_valid) begin
               active_lane_d = grant_idx;
               entry_d       = entry_arr[grant_idx];
               exit_d        = exit_arr[grant_idx];
               id_d          = id_arr[grant_idx];
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            calc_start = 1'b1;
            armed_d    = 1'b0;
            cnt_d      = '0;
            err_d      = 1'b0;
            state_d    = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Arming on a low sample guarantees a valid still held high from
            // the previous operation is never mistaken for this result.
            if (armed_q && calc_fee_valid) begin
               fee_d   = calc_fee_amount;
               err_d   = 1'b0;
               state_d = RESPOND;
            end else if (cnt_q == CNT_LAST) begin
               fee_d   = '0;
               err_d   = 1'b1;
               state_d = RESPOND;
            end else if (!calc_fee_valid) begin
               armed_d = 1'b1;
            end
         end
         RESPOND: begin
            lane_done    = err_q ? '0 : active_vec;
            lane_error   = err_q ? active_vec : '0;
            last_grant_d = active_lane_q;
            mask_d       = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         last_grant_q  <= LANE_W'(NUM_LANES - 1);
         active_lane_q <= '0;
         entry_q       <= '0;
         exit_q        <= '0;
         id_q          <= '0;
         fee_q         <= '0;
         cnt_q         <= '0;
         armed_q       <= 1'b0;
         err_q         <= 1'b0;
         mask_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         active_lane_q <= active_lane_d;
         entry_q       <= entry_d;
         exit_q        <= exit_d;
         id_q          <= id_d;
         fee_q         <= fee_d;
         cnt_q         <= cnt_d;
         armed_q       <= armed_d;
         err_q         <= err_d;
         mask_q        <= mask_d;
      end
   end

   assign lane_fee        = fee_q;
   assign calc_entry_time = entry_q;
   assign calc_exit_time  = exit_q;
   assign calc_vehicle_id = id_q;
   assign active_lane     = active_lane_q;

endmodule

// File: tb/tb_fee_lane_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fee_lane_scheduler
//   Directed scenarios followed by randomized lane traffic. A behavioural
//   calculator model answers calc_start, and a transaction-level reference
//   (pending-request set, round-robin pointer, fee table) predicts each grant,
//   operand set, completion pulse, fee and latency.
// -----------------------------------------------------------------------------
module tb_fee_lane_scheduler;
   import parking_pkg::*;

   localparam int N  = 4;
   localparam int TO = 64;
   localparam int M_PULSE = 0;
   localparam int M_HOLD  = 1;
   localparam int M_NEVER = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    lane_req;
   logic [32*N-1:0] lane_entry_time, lane_exit_time;
   logic [8*N-1:0]  lane_vehicle_id;
   logic [N-1:0]    lane_done, lane_error;
   logic [7:0]      lane_fee;
   logic            calc_start;
   logic [31:0]     calc_entry_time, calc_exit_time;
   logic [7:0]      calc_vehicle_id;
   logic [7:0]      calc_fee_amount;
   logic            calc_fee_valid;
   logic            busy;
   logic [1:0]      active_lane;

   logic [31:0] ent [N];
   logic [31:0] ext [N];
   logic [7:0]  vid [N];
   logic [7:0]  fee_tab [256];

   always_comb begin
      lane_entry_time = '0;
      lane_exit_time  = '0;
      lane_vehicle_id = '0;
      for (int i = 0; i < N; i++) begin
         lane_entry_time[32*i +: 32] = ent[i];
         lane_exit_time[32*i +: 32]  = ext[i];
         lane_vehicle_id[8*i +: 8]   = vid[i];
      end
   end

   fee_lane_scheduler #(.NUM_LANES(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk             (clk),
      .reset           (reset),
      .lane_req        (lane_req),
      .lane_entry_time (lane_entry_time),
      .lane_exit_time  (lane_exit_time),
      .lane_vehicle_id (lane_vehicle_id),
      .lane_done       (lane_done),
      .lane_error      (lane_error),
      .lane_fee        (lane_fee),
      .calc_start      (calc_start),
      .calc_entry_time (calc_entry_time),
      .calc_exit_time  (calc_exit_time),
      .calc_vehicle_id (calc_vehicle_id),
      .calc_fee_amount (calc_fee_amount),
      .calc_fee_valid  (calc_fee_valid),
      .busy            (busy),
      .active_lane     (active_lane)
   );

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // reference state
   bit       sb_en = 1'b0;
   bit       sb_inflight = 1'b0;
   int       sb_lane = 0;
   int       sb_last = N - 1;
   int       sb_start = 0;
   int       done_cyc = -100;
   bit       prev_idle = 1'b1;
   int       op_mode = M_PULSE;
   int       served_q[$];
   int       n_starts = 0;
   int       n_errs_seen = 0;
   logic [N-1:0] last_vec = '0;
   logic [7:0]   last_fee = '0;
   bit       hold_extra [N];
   int       drop_lane = 0;
   int       drop_cnt = 0;

   // calculator model state
   bit cm_active = 1'b0;
   int cm_cnt = 0;
   int cm_phase = 0;
   int cm_mode = M_PULSE;
   int cm_rise = 0;
   int mode_q[$];
   int delay_q[$];
   bit rand_ops = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic scoreboard();
      logic [N-1:0] elig;
      logic [N-1:0] exp_vec;
      bit           exp_start;
      bit           completed;
      int           exp_l;
      completed = 1'b0;
      elig = lane_req;
      if ((cyc - 1) == done_cyc + 1) elig[sb_last] = 1'b0;
      exp_start = prev_idle && (elig != '0);
      check_val("calc_start", calc_start, exp_start);
      if (calc_start && exp_start) begin
         exp_l = -1;
         for (int k = 1; k <= N; k++) begin
            if (elig[(sb_last + k) % N]) begin
               exp_l = (sb_last + k) % N;
               break;
            end
         end
         check_val("grant_lane", active_lane, exp_l);
         check_val("start_ops", {calc_entry_time, calc_exit_time}, {ent[exp_l], ext[exp_l]});
         check_val("start_id", calc_vehicle_id, vid[exp_l]);
         sb_inflight = 1'b1;
         sb_lane = exp_l;
         sb_start = cyc;
         n_starts++;
         served_q.push_back(exp_l);
      end
      if (lane_done != '0 || lane_error != '0) begin
         check_val("resp_in_flight", sb_inflight, 1);
         if (sb_inflight) begin
            exp_vec = 4'b0001 << sb_lane;
            if (op_mode == M_NEVER) begin
               check_val("err_vec", lane_error, exp_vec);
               check_val("err_no_done", lane_done, 0);
               check_val("err_fee", lane_fee, 0);
               check_val("err_latency", cyc, sb_start + 1 + TO);
               n_errs_seen++;
            end else begin
               check_val("done_vec", lane_done, exp_vec);
               check_val("done_no_err", lane_error, 0);
               check_val("done_fee", lane_fee, fee_tab[vid[sb_lane]]);
               check_val("done_latency", cyc, cm_rise + 1);
            end
            check_val("hold_ops", {calc_entry_time, calc_exit_time}, {ent[sb_lane], ext[sb_lane]});
            check_val("hold_id", calc_vehicle_id, vid[sb_lane]);
            last_vec = lane_done | lane_error;
            last_fee = lane_fee;
            sb_last = sb_lane;
            done_cyc = cyc;
            completed = 1'b1;
            sb_inflight = 1'b0;
            if (hold_extra[sb_lane]) begin
               drop_lane = sb_lane;
               drop_cnt = 3;
            end else begin
               lane_req[sb_lane] = 1'b0;
            end
         end
      end else if (sb_inflight && (cyc - sb_start) > TO + 40) begin
         check_val("watchdog", 0, 1);
         sb_inflight = 1'b0;
      end
      check_val("busy", busy, sb_inflight || completed);
      prev_idle = !(sb_inflight || completed);
   endtask

   task automatic calc_model();
      if (calc_start) begin
         cm_active = 1'b1;
         cm_phase = 0;
         if (mode_q.size() > 0) cm_mode = mode_q.pop_front();
         else if (rand_ops) cm_mode = ($urandom_range(0, 9) < 7) ? M_PULSE :
                                      ($urandom_range(0, 2) < 2) ? M_HOLD : M_NEVER;
         else cm_mode = M_PULSE;
         if (delay_q.size() > 0) cm_cnt = delay_q.pop_front();
         else cm_cnt = rand_ops ? int'($urandom_range(0, 4)) : 1;
         op_mode = cm_mode;
         if (cm_mode == M_NEVER) begin
            calc_fee_valid = 1'b0;
            cm_active = 1'b0;
         end
      end else if (cm_active) begin
         if (cm_cnt > 0) begin
            cm_cnt--;
            if (cm_mode != M_HOLD) calc_fee_valid = 1'b0;
         end else if (cm_phase == 0) begin
            calc_fee_valid = 1'b0;
            cm_phase = 1;
         end else if (cm_phase == 1) begin
            calc_fee_valid = 1'b1;
            calc_fee_amount = fee_tab[calc_vehicle_id];
            cm_rise = cyc;
            cm_phase = 2;
         end else begin
            if (cm_mode != M_HOLD) calc_fee_valid = 1'b0;
            cm_active = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (sb_en) scoreboard();
      if (sb_en) calc_model();
      if (drop_cnt > 0) begin
         drop_cnt--;
         if (drop_cnt == 0) lane_req[drop_lane] = 1'b0;
      end
   endtask

   task automatic raise(input int l, input logic [31:0] e, input logic [31:0] x,
                        input logic [7:0] id, input logic [7:0] fee);
      ent[l] = e;
      ext[l] = x;
      vid[l] = id;
      fee_tab[id] = fee;
      lane_req[l] = 1'b1;
   endtask

   // Called at a negedge; asserts reset, checks outputs clear at once.
   task automatic apply_reset();
      sb_en = 1'b0;
      reset = 1'b1;
      #1;
      check_val("rst_ctl", {lane_done, lane_error, lane_fee, calc_start, busy, active_lane}, 0);
      check_val("rst_ops", {calc_entry_time, calc_exit_time}, 0);
      check_val("rst_id", calc_vehicle_id, 0);
      repeat (2) begin
         tick();
         check_val("rst_no_resp", {lane_done, lane_error}, 0);
      end
      sb_inflight = 1'b0;
      sb_last = N - 1;
      done_cyc = -100;
      prev_idle = 1'b1;
      cm_active = 1'b0;
      calc_fee_valid = 1'b0;
      calc_fee_amount = '0;
      drop_cnt = 0;
      mode_q.delete();
      delay_q.delete();
      served_q.delete();
      reset = 1'b0;
      sb_en = 1'b1;
   endtask

   task automatic wait_quiet(input int budget, input string tag);
      bit quiet;
      quiet = 1'b0;
      for (int i = 0; i < budget && !quiet; i++) begin
         tick();
         quiet = (lane_req == '0) && !sb_inflight && (drop_cnt == 0);
      end
      if (!quiet) check_val({tag, "_budget"}, 0, 1);
   endtask

   task automatic wait_inflight(input int budget, input string tag);
      for (int i = 0; i < budget && !sb_inflight; i++) tick();
      if (!sb_inflight) check_val({tag, "_start_budget"}, 0, 1);
   endtask

   initial begin
      int base;
      lane_req = '0;
      calc_fee_valid = 1'b0;
      calc_fee_amount = '0;
      for (int i = 0; i < N; i++) begin
         ent[i] = '0;
         ext[i] = '0;
         vid[i] = '0;
         hold_extra[i] = 1'b0;
      end
      for (int i = 0; i < 256; i++) fee_tab[i] = '0;
      @(negedge clk);
      apply_reset();

      // single lane with known operands
      n_starts = 0;
      mode_q.push_back(M_PULSE);
      delay_q.push_back(2);
      raise(2, 100, 220, 8'd2, 8'd20);
      wait_quiet(100, "t_single");
      check_val("t_single_starts", n_starts, 1);
      check_val("t_single_vec", last_vec, 4'b0100);
      check_val("t_single_fee", last_fee, 20);

      // all four lanes at once after reset
      tick();
      apply_reset();
      n_starts = 0;
      for (int l = 0; l < N; l++) raise(l, 1000 * l, 1000 * l + 60 * (l + 1), 8'h30 + 8'(l), 8'(7 * (l + 1)));
      wait_quiet(200, "t_all4");
      check_val("t_all4_starts", n_starts, 4);
      check_val("t_all4_count", served_q.size(), 4);
      for (int i = 0; i < served_q.size() && i < 4; i++) check_val($sformatf("t_all4_order%0d", i), served_q[i], i);

      // timeout on lane 1, then lane 2 served normally
      served_q.delete();
      base = n_errs_seen;
      mode_q.push_back(M_NEVER);
      mode_q.push_back(M_PULSE);
      raise(1, 40, 90, 8'h41, 8'd9);
      raise(2, 50, 95, 8'h42, 8'd11);
      wait_quiet(300, "t_timeout");
      check_val("t_timeout_errs", n_errs_seen - base, 1);
      check_val("t_timeout_count", served_q.size(), 2);
      if (served_q.size() == 2) check_val("t_timeout_next", served_q[1], 2);
      check_val("t_timeout_fee2", last_fee, 11);

      // valid held high across operations
      mode_q.push_back(M_HOLD);
      delay_q.push_back(1);
      raise(0, 10, 70, 8'h50, 8'd10);
      wait_quiet(100, "t_hold_a");
      check_val("t_hold_a_fee", last_fee, 10);
      check_val("t_hold_level", calc_fee_valid, 1);
      mode_q.push_back(M_HOLD);
      delay_q.push_back(3);
      raise(0, 500, 800, 8'h51, 8'd35);
      wait_quiet(100, "t_hold_b");
      check_val("t_hold_b_fee", last_fee, 35);

      // reset in WAIT drops the operation; lane 0 first afterwards
      mode_q.push_back(M_NEVER);
      raise(2, 300, 420, 8'h62, 8'd44);
      wait_inflight(20, "t_rstwait");
      repeat (5) tick();
      apply_reset();
      raise(0, 11, 22, 8'h70, 8'd3);
      raise(3, 33, 44, 8'h73, 8'd5);
      wait_quiet(200, "t_rstwait");
      check_val("t_rstwait_count", served_q.size(), 3);
      if (served_q.size() > 0) check_val("t_rstwait_first", served_q[0], 0);

      // lane 1 holds req one cycle past done while lane 3 requests
      tick();
      apply_reset();
      hold_extra[1] = 1'b1;
      raise(1, 5, 65, 8'h81, 8'd13);
      wait_inflight(20, "t_late");
      raise(3, 6, 99, 8'h83, 8'd17);
      wait_quiet(200, "t_late");
      check_val("t_late_count", served_q.size(), 2);
      if (served_q.size() == 2) check_val("t_late_next", served_q[1], 3);
      // lane 1 alone dropping late must not be served twice
      n_starts = 0;
      raise(1, 7, 77, 8'h85, 8'd19);
      wait_quiet(100, "t_late_solo");
      repeat (5) tick();
      check_val("t_late_solo_starts", n_starts, 1);
      hold_extra[1] = 1'b0;

      // randomized traffic
      rand_ops = 1'b1;
      for (int t = 0; t < 2500; t++) begin
         tick();
         for (int l = 0; l < N; l++) begin
            if (!lane_req[l] && $urandom_range(0, 7) == 0) begin
               base = int'($urandom_range(0, 100000));
               raise(l, base, base + int'($urandom_range(0, 5000)),
                     {6'($urandom_range(0, 63)), 2'(l)}, 8'($urandom_range(0, 255)));
            end
         end
      end
      wait_quiet(500, "t_random");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fee_lane_scheduler.md
FEE_LANE_SCHEDULER -- requirements
Module: fee_lane_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 4, meaning number of exit lanes sharing one Fee_calculator (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of WAIT cycles before a calculation is abandoned.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 lane_req  input  NUM_LANES  level request per lane, held until that lane's lane_done or lane_error.
REQ-006 lane_entry_time  input  32*NUM_LANES  packed entry timestamps; lane i occupies bits [32i+31:32i].
REQ-007 lane_exit_time  input  32*NUM_LANES  packed exit timestamps, same packing.
REQ-008 lane_vehicle_id  input  8*NUM_LANES  packed vehicle IDs; lane i occupies bits [8i+7:8i].
REQ-009 lane_done  output  NUM_LANES  one-hot, one-cycle pulse: fee ready for that lane.
REQ-010 lane_error  output  NUM_LANES  one-hot, one-cycle pulse: calculation timed out for that lane.
REQ-011 lane_fee  output  8  fee for the lane pulsed on lane_done; 0 on lane_error.
REQ-012 calc_start  output  1  one-cycle pulse driving calculate_fee of the Fee_calculator.
REQ-013 calc_entry_time / calc_exit_time  output  32 each  latched operands to the Fee_calculator.
REQ-014 calc_vehicle_id  output  8  latched vehicle ID to the Fee_calculator.
REQ-015 calc_fee_amount  input  8  fee_amount from the Fee_calculator.
REQ-016 calc_fee_valid  input  1  fee_valid from the Fee_calculator; may be pulsed or held.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 active_lane  output  $clog2(NUM_LANES)  index of the lane being served; holds its last value in IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESPOND.
REQ-020 IDLE: when any unmasked lane_req is high, select a lane round-robin starting at last_grant+1 (modulo NUM_LANES), latch that lane's time and ID slices into calc_* outputs, set active_lane, and go to ISSUE.
REQ-021 ISSUE: assert calc_start for exactly one cycle, clear armed flag and timeout counter, and go to WAIT.
REQ-022 WAIT: set armed when calc_fee_valid is sampled low; accept the result only when armed and calc_fee_valid is high, capturing calc_fee_amount, so a level-held valid from a prior operation is never accepted.
REQ-023 WAIT: the counter increments each cycle; if TIMEOUT_CYCLES cycles pass without acceptance, go to RESPOND with the error flag set.
REQ-024 RESPOND: pulse lane_done[active_lane] with the captured fee, or lane_error[active_lane] with lane_fee=0; update last_grant=active_lane; return to IDLE.
REQ-025 For one cycle after RESPOND, lane_req[last_grant] SHALL be masked in IDLE so a requester dropping req one cycle late is not re-served.
REQ-026 calc_* operand outputs SHALL remain stable from ISSUE through RESPOND.
REQ-027 lane_fee SHALL hold its value until the next RESPOND.
REQ-028 Latency: with the calculator idle, calc_start asserts 1 cycle after lane_req is first sampled in IDLE; lane_done asserts 1 cycle after the accepting WAIT cycle.
REQ-029 A lane_req deasserted before its grant SHALL not be served; deassertion after grant does not abort the operation.
REQ-030 Requests arriving in states other than IDLE SHALL wait and are arbitrated at the next IDLE.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE and clear all outputs to 0: lane_done, lane_error, lane_fee, calc_start, calc_*, busy, active_lane.
REQ-032 Asserting reset SHALL also clear the armed flag, the counter and the mask, and set last_grant=NUM_LANES-1 so that lane 0 has first priority.
REQ-033 Reset mid-operation SHALL drop the in-flight operation without a done or error pulse.

Structure
REQ-034 Package parking_pkg SHALL hold TIME_W=32, ID_W=8, FEE_W=8 and the FSM state enum.
REQ-035 The round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last_grant; outputs grant_valid, grant_idx).

Verification
REQ-036 Lane 2 requests entry=100, exit=220, id=2, and the model returns 20 -> calc_start once with operands 100/220/2, then lane_done=4'b0100 and lane_fee=20.
REQ-037 All four lanes request at once after reset -> served in order 0,1,2,3, with exactly one calc_start per lane and no overlap.
REQ-038 The model never asserts valid -> lane_error pulses for the lane exactly TIMEOUT_CYCLES=64 cycles after WAIT entry, lane_fee=0, then the next lane is served.
REQ-039 calc_fee_valid is held high from the previous operation -> not accepted until it drops and rises again, and the fee is the new value (e.g. 35 for entry=500, exit=800).
REQ-040 Reset asserted in WAIT -> all outputs are 0 in the same cycle, there is no lane_done, and the first grant after release goes to lane 0.
REQ-041 Lane 1 keeps req high one cycle past lane_done while lane 3 also requests -> lane 3 is served next and lane 1 is not re-served.
